arm_id_ctrl_stage: RTL and testbench

Registered decode/control stage for the ARM pipeline. It decodes opcode, mode, S and cond into the EXE control bundle and checks the condition code against the status flags. The result is held in an ID/EX control register with stall, flush and valid handling. After a taken branch, it squashes a parametrised number of younger instructions. It sits between the instruction-fetch register and the EXE stage and replaces the purely combinational control decode.

---
 rtl/arm_id_ctrl_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_arm_id_ctrl_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_id_ctrl_stage.sv
// arm_id_ctrl_stage: registered ARM decode/control stage (ID/EX control register).
// Decodes mode/opcode/S/cond into the EXE control bundle and checks the condition
// code against the status flags. Live results are registered with stall, flush and
// valid handling. After a taken branch, BR_SHADOW younger instructions are squashed.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   in_valid        : decode inputs carry a real instruction
//   opcode, mode    : instruction bits [24:21] and [27:26]
//   s_bit           : S bit (data processing) / L bit (memory, 1 = load)
//   cond, nzcv      : condition field [31:28] and status flags {N,Z,C,V}
//   stall, flush    : hold / kill the ID/EX register (flush wins)
//   out_valid       : registered bundle is a live instruction
//   exe_cmd, s_out, b_out, mem_w_en, mem_r_en, wb_en : registered controls
//   illegal_pulse   : one-cycle pulse when an illegal instruction is accepted
//   illegal_cnt     : saturating illegal-instruction count
//
// Configuration macro: ARM_ID_COND_CHECK_EN
//   defined   : condition field is checked against nzcv (1111 never passes)
//   undefined : every cond value is treated as AL, nzcv is ignored
module arm_id_ctrl_stage #(
  parameter int unsigned EXE_CMD_W = 4,
  parameter int unsigned BR_SHADOW = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           opcode,
  input  logic [1:0]           mode,
  input  logic                 s_bit,
  input  logic [3:0]           cond,
  input  logic [3:0]           nzcv,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 s_out,
  output logic                 b_out,
  output logic                 mem_w_en,
  output logic                 mem_r_en,
  output logic                 wb_en,
  output logic                 illegal_pulse,
  output logic [CNT_W-1:0]     illegal_cnt
);

  localparam int unsigned SH_W = 4;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Combinational decode results
  logic                 dec_legal;
  logic [EXE_CMD_W-1:0] dec_cmd;
  logic                 dec_s;
  logic                 dec_b;
  logic                 dec_mw;
  logic                 dec_mr;
  logic                 dec_wb;
  logic                 cond_pass;

  // ID/EX register and bookkeeping state
  logic                 out_valid_q, out_valid_d;
  logic [EXE_CMD_W-1:0] exe_cmd_q, exe_cmd_d;
  logic                 s_out_q, s_out_d;
  logic                 b_out_q, b_out_d;
  logic                 mem_w_en_q, mem_w_en_d;
  logic                 mem_r_en_q, mem_r_en_d;
  logic                 wb_en_q, wb_en_d;
  logic                 illegal_pulse_q, illegal_pulse_d;
  logic [CNT_W-1:0]     illegal_cnt_q, illegal_cnt_d;
  logic [SH_W-1:0]      shadow_q, shadow_d;

  // Instruction decode: mode/opcode/S into the control bundle
  always_comb begin
    dec_legal = 1'b0;
    dec_cmd   = EXE_CMD_W'(CMD_NOP);
    dec_s     = 1'b0;
    dec_b     = 1'b0;
    dec_mw    = 1'b0;
    dec_mr    = 1'b0;
    dec_wb    = 1'b0;
    case (mode)
      2'b00: begin
        dec_legal = 1'b1;
        dec_wb    = 1'b1;
        dec_s     = s_bit;
        case (opcode)
          4'b1101: dec_cmd = EXE_CMD_W'(CMD_MOV);
          4'b1111: dec_cmd = EXE_CMD_W'(CMD_MVN);
          4'b0100: dec_cmd = EXE_CMD_W'(CMD_ADD);
          4'b0101: dec_cmd = EXE_CMD_W'(CMD_ADC);
          4'b0010: dec_cmd = EXE_CMD_W'(CMD_SUB);
          4'b0110: dec_cmd = EXE_CMD_W'(CMD_SBC);
          4'b0000: dec_cmd = EXE_CMD_W'(CMD_AND);
          4'b1100: dec_cmd = EXE_CMD_W'(CMD_ORR);
          4'b0001: dec_cmd = EXE_CMD_W'(CMD_EOR);
          // Compare/test only update flags
          4'b1010: begin
            dec_cmd = EXE_CMD_W'(CMD_SUB);
            dec_wb  = 1'b0;
            dec_s   = 1'b1;
          end
          4'b1000: begin
            dec_cmd = EXE_CMD_W'(CMD_AND);
            dec_wb  = 1'b0;
            dec_s   = 1'b1;
          end
          default: begin
            dec_legal = 1'b0;
            dec_wb    = 1'b0;
            dec_s     = 1'b0;
          end
        endcase
      end
      2'b01: begin
        if (opcode == 4'b0100) begin
          dec_legal = 1'b1;
          dec_cmd   = EXE_CMD_W'(CMD_ADD);
          dec_mr    = s_bit;
          dec_mw    = ~s_bit;
          dec_wb    = s_bit;
        end
      end
      2'b10: begin
        dec_legal = 1'b1;
        dec_b     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARM_ID_COND_CHECK_EN
  // ARM condition table against {N,Z,C,V}
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = nzcv[2];
      4'b0001: cond_pass = ~nzcv[2];
      4'b0010: cond_pass = nzcv[1];
      4'b0011: cond_pass = ~nzcv[1];
      4'b0100: cond_pass = nzcv[3];
      4'b0101: cond_pass = ~nzcv[3];
      4'b0110: cond_pass = nzcv[0];
      4'b0111: cond_pass = ~nzcv[0];
      4'b1000: cond_pass = nzcv[1] & ~nzcv[2];
      4'b1001: cond_pass = ~nzcv[1] | nzcv[2];
      4'b1010: cond_pass = (nzcv[3] == nzcv[0]);
      4'b1011: cond_pass = (nzcv[3] != nzcv[0]);
      4'b1100: cond_pass = ~nzcv[2] & (nzcv[3] == nzcv[0]);
      4'b1101: cond_pass = nzcv[2] | (nzcv[3] != nzcv[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  // Every condition behaves as AL; cond/nzcv are deliberately unused
  logic unused_cond_bits;
  assign unused_cond_bits = ^{cond, nzcv};
  assign cond_pass        = 1'b1;
`endif

  // Next-state: flush beats stall; squash beats illegal; illegal is judged
  // on encoding alone, independent of the condition outcome.
  always_comb begin
    out_valid_d     = out_valid_q;
    exe_cmd_d       = exe_cmd_q;
    s_out_d         = s_out_q;
    b_out_d         = b_out_q;
    mem_w_en_d      = mem_w_en_q;
    mem_r_en_d      = mem_r_en_q;
    wb_en_d         = wb_en_q;
    illegal_pulse_d = 1'b0;
    illegal_cnt_d   = illegal_cnt_q;
    shadow_d        = shadow_q;

    if (flush || !stall) begin
      out_valid_d = 1'b0;
      exe_cmd_d   = '0;
      s_out_d     = 1'b0;
      b_out_d     = 1'b0;
      mem_w_en_d  = 1'b0;
      mem_r_en_d  = 1'b0;
      wb_en_d     = 1'b0;
    end

    if (flush) begin
      shadow_d = '0;
    end else if (!stall && in_valid) begin
      if (shadow_q != '0) begin
        shadow_d = shadow_q - SH_W'(1);
      end else if (!dec_legal) begin
        illegal_pulse_d = 1'b1;
        if (illegal_cnt_q != {CNT_W{1'b1}}) begin
          illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
      end else if (cond_pass) begin
        out_valid_d = 1'b1;
        exe_cmd_d   = dec_cmd;
        s_out_d     = dec_s;
        b_out_d     = dec_b;
        mem_w_en_d  = dec_mw;
        mem_r_en_d  = dec_mr;
        wb_en_d     = dec_wb;
        if (dec_b) begin
          shadow_d = SH_W'(BR_SHADOW);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      exe_cmd_q       <= '0;
      s_out_q         <= 1'b0;
      b_out_q         <= 1'b0;
      mem_w_en_q      <= 1'b0;
      mem_r_en_q      <= 1'b0;
      wb_en_q         <= 1'b0;
      illegal_pulse_q <= 1'b0;
      illegal_cnt_q   <= '0;
      shadow_q        <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      exe_cmd_q       <= exe_cmd_d;
      s_out_q         <= s_out_d;
      b_out_q         <= b_out_d;
      mem_w_en_q      <= mem_w_en_d;
      mem_r_en_q      <= mem_r_en_d;
      wb_en_q         <= wb_en_d;
      illegal_pulse_q <= illegal_pulse_d;
      illegal_cnt_q   <= illegal_cnt_d;
      shadow_q        <= shadow_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign exe_cmd       = exe_cmd_q;
  assign s_out         = s_out_q;
  assign b_out         = b_out_q;
  assign mem_w_en      = mem_w_en_q;
  assign mem_r_en      = mem_r_en_q;
  assign wb_en         = wb_en_q;
  assign illegal_pulse = illegal_pulse_q;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_arm_id_ctrl_stage.sv
// Testbench for arm_id_ctrl_stage: directed and random stimulus, reference model
// predictions queued per edge and compared by an independent monitor.
module tb_arm_id_ctrl_stage;

  localparam int unsigned EXE_CMD_W = 4;
  localparam int unsigned BR_SHADOW = 2;
  localparam int unsigned CNT_W     = 8;
  localparam int          CNT_MAX   = 255;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] opcode;
  logic [1:0] mode;
  logic       s_bit;
  logic [3:0] cond;
  logic [3:0] nzcv;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic [3:0] exe_cmd;
  logic       s_out, b_out, mem_w_en, mem_r_en, wb_en, illegal_pulse;
  logic [7:0] illegal_cnt;

  arm_id_ctrl_stage #(
    .EXE_CMD_W(EXE_CMD_W),
    .BR_SHADOW(BR_SHADOW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .opcode       (opcode),
    .mode         (mode),
    .s_bit        (s_bit),
    .cond         (cond),
    .nzcv         (nzcv),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .exe_cmd      (exe_cmd),
    .s_out        (s_out),
    .b_out        (b_out),
    .mem_w_en     (mem_w_en),
    .mem_r_en     (mem_r_en),
    .wb_en        (wb_en),
    .illegal_pulse(illegal_pulse),
    .illegal_cnt  (illegal_cnt)
  );

  typedef struct {
    logic       ov;
    logic [3:0] cmd;
    logic       s, b, mw, mr, wb, pulse;
    logic [7:0] cnt;
    int unsigned cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int unsigned edge_cnt = 0;

  // Reference model state
  exp_t m_out;
  int   m_shadow;
  int   m_cnt;

  // Mode-00 ALU command per opcode; -1 marks an illegal opcode
  int alu_cmd[16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t zero_bundle();
    exp_t e;
    e.ov = 0; e.cmd = 0; e.s = 0; e.b = 0; e.mw = 0; e.mr = 0; e.wb = 0;
    e.pulse = 0; e.cnt = 0; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t e;
    e.ov = out_valid; e.cmd = exe_cmd; e.s = s_out; e.b = b_out;
    e.mw = mem_w_en; e.mr = mem_r_en; e.wb = wb_en;
    e.pulse = illegal_pulse; e.cnt = illegal_cnt; e.cyc = edge_cnt;
    return e;
  endfunction

  function automatic logic [18:0] pk(exp_t e);
    return {e.ov, e.cmd, e.s, e.b, e.mw, e.mr, e.wb, e.pulse, e.cnt};
  endfunction

  task automatic check(input string nm, input exp_t got, input exp_t want);
    n_checks++;
    if (pk(got) !== pk(want)) begin
      n_errors++;
      $display("FAIL %s edge=%0d got ov=%b cmd=%h s=%b b=%b mw=%b mr=%b wb=%b pulse=%b cnt=%0d required ov=%b cmd=%h s=%b b=%b mw=%b mr=%b wb=%b pulse=%b cnt=%0d",
               nm, want.cyc, got.ov, got.cmd, got.s, got.b, got.mw, got.mr, got.wb, got.pulse, got.cnt,
               want.ov, want.cmd, want.s, want.b, want.mw, want.mr, want.wb, want.pulse, want.cnt);
    end
  endtask

  // Condition: pairs of codes share a base test; the odd code inverts it
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base, res;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    res = c[0] ? !base : base;
`ifndef ARM_ID_COND_CHECK_EN
    res = 1'b1;
`endif
    return res;
  endfunction

  function automatic bit ref_decode(input logic [1:0] md, input logic [3:0] op,
                                    input bit sb, output exp_t d);
    d = zero_bundle();
    if (md == 2'd2) begin
      d.b = 1;
      return 1;
    end
    if (md == 2'd1) begin
      if (op != 4'd4) return 0;
      d.cmd = 4'd2; d.mr = sb; d.mw = !sb; d.wb = sb;
      return 1;
    end
    if (md == 2'd0 && alu_cmd[op] >= 0) begin
      d.cmd = 4'(alu_cmd[op]);
      if (op == 4'd8 || op == 4'd10) begin d.wb = 0; d.s = 1; end
      else begin d.wb = 1; d.s = sb; end
      return 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_out = zero_bundle();
    m_shadow = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit iv, input logic [1:0] md, input logic [3:0] op,
                            input bit sb, input logic [3:0] cd, input logic [3:0] nz,
                            input bit st, input bit fl, output exp_t n);
    exp_t d;
    n = m_out;
    n.pulse = 0;
    if (fl) begin
      n = zero_bundle();
      m_shadow = 0;
    end else if (!st) begin
      n = zero_bundle();
      if (iv) begin
        if (m_shadow > 0) m_shadow--;
        else if (!ref_decode(md, op, sb, d)) begin
          n.pulse = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else if (cond_ok(cd, nz)) begin
          n = d;
          n.ov = 1;
          if (md == 2'd2) m_shadow = BR_SHADOW;
        end
      end
    end
    n.cnt = 8'(m_cnt);
    m_out = n;
  endtask

  // One cycle of stimulus; the prediction is tagged with the edge it applies to
  task automatic drive(input bit iv, input logic [1:0] md, input logic [3:0] op,
                       input bit sb, input logic [3:0] cd, input logic [3:0] nz,
                       input bit st, input bit fl);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = iv; mode = md; opcode = op; s_bit = sb; cond = cd; nzcv = nz;
    stall = st; flush = fl;
    model_step(iv, md, op, sb, cd, nz, st, fl, e);
    e.cyc = edge_cnt + 1;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    in_valid = 0; mode = 0; opcode = 0; s_bit = 0; cond = 0; nzcv = 0;
    stall = 0; flush = 0;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge
  task automatic async_reset();
    exp_t z;
    #3;
    rst = 1'b1;
    #1;
    z = zero_bundle();
    z.cyc = edge_cnt;
    check("async_rst", sample(), z);
    sb_q.delete();
    model_reset();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every edge that has a prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
        e = sb_q.pop_front();
        if (e.cyc != edge_cnt) begin
          n_checks++;
          n_errors++;
          $display("FAIL stale_entry got edge=%0d required edge=%0d", edge_cnt, e.cyc);
        end else begin
          check("bundle", sample(), e);
        end
      end
    end
  end

  initial begin
    exp_t z;
    logic [3:0] legal_ops[12] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8, 4'h4};
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    z = zero_bundle();
    check("reset", sample(), z);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic decode
    drive(1, 2'b00, 4'b0100, 1, 4'hE, 4'h0, 0, 0);   // ADDS
    drive(1, 2'b01, 4'b0100, 0, 4'hE, 4'h0, 0, 0);   // STR
    drive(1, 2'b01, 4'b0100, 1, 4'hE, 4'h0, 0, 0);   // LDR
    drive(1, 2'b00, 4'b1010, 0, 4'hE, 4'h0, 0, 0);   // CMP
    drive(1, 2'b00, 4'b1111, 0, 4'hE, 4'h0, 0, 0);   // MVN
    // Condition check
    drive(1, 2'b00, 4'b0100, 0, 4'h0, 4'b0000, 0, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'h0, 4'b0100, 0, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'hF, 4'b0100, 0, 0);
    // Branch shadow with a stall in the middle
    drive(1, 2'b10, 4'b0000, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 1, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    // Idle cycles do not consume shadow
    drive(1, 2'b10, 4'b0011, 0, 4'hE, 4'h0, 0, 0);
    drive(0, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b11, 4'b0100, 0, 4'hE, 4'h0, 0, 0);   // squashed, not illegal
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    // Stall+flush over a live MOV, flush clearing shadow
    drive(1, 2'b00, 4'b1101, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b00, 4'b1101, 0, 4'hE, 4'h0, 1, 1);
    drive(1, 2'b10, 4'b0000, 0, 4'hE, 4'h0, 0, 0);
    drive(0, 2'b00, 4'b0000, 0, 4'hE, 4'h0, 0, 1);
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b10, 4'b0000, 0, 4'hE, 4'h0, 0, 1);   // flush beats branch load
    drive(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    // Illegal saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 2'b11, 4'($urandom), 1'($urandom), 4'hE, 4'h0, 0, 0);
    end
    drive(1, 2'b11, 4'h0, 0, 4'hE, 4'h0, 1, 0);
    drive(1, 2'b00, 4'b1101, 1, 4'hE, 4'h0, 0, 0);
    async_reset();
    drive(1, 2'b00, 4'b0100, 1, 4'hE, 4'h0, 0, 0);
    drive(1, 2'b00, 4'b1110, 1, 4'hE, 4'h0, 0, 0);   // illegal after reset -> cnt 1

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op, cd;
      op = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 11)] : 4'($urandom);
      cd = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
      drive($urandom_range(0, 7) != 0, 2'($urandom), op, 1'($urandom), cd, 4'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    for (int i = 0; i < 3; i++) drive(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending predictions required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
